// File: rtl/register_file_pkg.sv
// Shared constants for the register file slice.
// Width, depth, select width and the hard-wired zero index.
package register_file_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int SEL_W    = 4;
   localparam int R0       = 0;

endpackage

// File: rtl/register_file_reg_cell.sv
// Single storage register for the register file.
// Async active-low clear with a write enable.
module reg_cell
   import register_file_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/register_file.sv
// Register file on a shared tri-state bus.
// r0 reads as zero; r1..r15 are reg_cell instances.
module register_file #(
   parameter int DATA_W   = register_file_pkg::DATA_W,
   parameter int NUM_REGS = register_file_pkg::NUM_REGS,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] register_select,
   input  logic             reg_file_in,
   input  logic             reg_file_out,
   inout  wire [DATA_W-1:0] data
);

   import register_file_pkg::*;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_val;
   logic              wr;
   logic              drive;

   // a read request always wins over a simultaneous write strobe
   assign wr = reg_file_in & ~reg_file_out;

   assign regs[R0] = '0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
      reg_cell #(
         .W (DATA_W)
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .en  (wr && (register_select == SEL_W'(i))),
         .d   (data),
         .q   (regs[i])
      );
   end

   assign rd_val = regs[register_select];
   assign drive  = reg_file_out & rst;
   assign data   = drive ? rd_val : {DATA_W{1'bz}};

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file with an array reference model.
// Bus contention is probed by driving the bus while the DUT should be idle.
`timescale 1ns/1ps
module tb_register_file;

   logic        clk;
   logic        rst;
   logic [3:0]  register_select;
   logic        reg_file_in;
   logic        reg_file_out;
   logic [15:0] drv;
   logic        drv_en;
   wire  [15:0] data;

   int n_checks;
   int n_fail;
   logic [15:0] model [16];

   assign data = drv_en ? drv : 16'hzzzz;

   register_file dut (
      .clk             (clk),
      .rst             (rst),
      .register_select (register_select),
      .reg_file_in     (reg_file_in),
      .reg_file_out    (reg_file_out),
      .data            (data)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: write if strobed, not reading, not r0; reset clears all
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) model[i] = 16'h0000;
      end else if (reg_file_in && !reg_file_out && drv_en
                   && register_select != 4'd0) begin
         model[register_select] = drv;
      end
   end

   // per-cycle compare of the bus against the model
   always @(negedge clk) begin
      if (rst && reg_file_out && !drv_en)
         check("bus_read", data, model[register_select]);
      else if (!reg_file_out && drv_en)
         check("bus_idle", data, drv);
   end

   task automatic wr_reg(input logic [3:0] sel, input logic [15:0] val);
      register_select = sel;
      drv             = val;
      drv_en          = 1'b1;
      reg_file_in     = 1'b1;
      reg_file_out    = 1'b0;
      @(posedge clk); #1;
      reg_file_in     = 1'b0;
      drv_en          = 1'b0;
   endtask

   task automatic rd_reg(input string name, input logic [3:0] sel,
                         input logic [15:0] exp);
      drv_en          = 1'b0;
      reg_file_in     = 1'b0;
      reg_file_out    = 1'b1;
      register_select = sel;
      #2;
      check(name, data, exp);
      @(posedge clk); #1;
      reg_file_out    = 1'b0;
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      rst             = 1'b0;
      register_select = 4'd0;
      reg_file_in     = 1'b0;
      reg_file_out    = 1'b0;
      drv             = 16'h0000;
      drv_en          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // reset state of a few registers
      rd_reg("reset_r1", 4'd1, 16'h0000);
      rd_reg("reset_r15", 4'd15, 16'h0000);

      // first write after reset, then readback
      wr_reg(4'd1, 16'h002A);
      rd_reg("basic_r1", 4'd1, 16'h002A);

      // patterns, no cross-writes
      wr_reg(4'd1, 16'h0001);
      wr_reg(4'd14, 16'h000E);
      wr_reg(4'd15, 16'hFFFF);
      rd_reg("pat_r1", 4'd1, 16'h0001);
      rd_reg("pat_r14", 4'd14, 16'h000E);
      rd_reg("pat_r15", 4'd15, 16'hFFFF);
      rd_reg("pat_r2", 4'd2, 16'h0000);
      rd_reg("pat_r13", 4'd13, 16'h0000);

      // r0 is hard-wired to zero
      wr_reg(4'd0, 16'h1234);
      rd_reg("r0_zero", 4'd0, 16'h0000);

      // same-cycle select change while reading
      reg_file_out    = 1'b1;
      register_select = 4'd14;
      #1 check("sel_r14", data, 16'h000E);
      register_select = 4'd15;
      #1 check("sel_r15", data, 16'hFFFF);
      register_select = 4'd1;
      #1 check("sel_r1", data, 16'h0001);
      @(posedge clk); #1;
      reg_file_out = 1'b0;

      // bus idle: DUT must not fight a zero driven by the bench
      drv_en = 1'b1;
      drv    = 16'h0000;
      for (int s = 0; s < 16; s++) begin
         register_select = 4'(s);
         #1 check("idle_bus", data, 16'h0000);
      end
      drv_en = 1'b0;
      @(posedge clk); #1;

      // simultaneous in/out is a read: r2 keeps its value
      wr_reg(4'd2, 16'h00F0);
      register_select = 4'd2;
      reg_file_in     = 1'b1;
      reg_file_out    = 1'b1;
      drv             = 16'h000F;
      drv_en          = 1'b1;
      @(posedge clk); #1;
      drv_en          = 1'b0;
      reg_file_in     = 1'b0;
      reg_file_out    = 1'b0;
      rd_reg("rw_hold_r2", 4'd2, 16'h00F0);
      rd_reg("model_r2", 4'd2, model[2]);

      // async reset between edges, checked before any clock edge
      wr_reg(4'd1, 16'h002A);
      wr_reg(4'd15, 16'h00FF);
      rd_reg("pre_rst_r15", 4'd15, 16'h00FF);
      rst          = 1'b0;
      #1;
      rst          = 1'b1;
      reg_file_out = 1'b1;
      register_select = 4'd1;
      #1 check("arst_r1", data, 16'h0000);
      register_select = 4'd15;
      #1 check("arst_r15", data, 16'h0000);
      register_select = 4'd14;
      #1 check("arst_r14", data, 16'h0000);
      @(posedge clk); #1;
      reg_file_out = 1'b0;

      // reset asserted across a write strobe wins
      register_select = 4'd3;
      drv             = 16'hBEEF;
      drv_en          = 1'b1;
      reg_file_in     = 1'b1;
      rst             = 1'b0;
      @(posedge clk); #1;
      reg_file_in     = 1'b0;
      drv_en          = 1'b0;
      rst             = 1'b1;
      rd_reg("rst_wins_r3", 4'd3, 16'h0000);

      // writes accepted from first edge after release
      wr_reg(4'd5, 16'h5A5A);
      rd_reg("post_rst_r5", 4'd5, 16'h5A5A);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
